// File: rtl/seg7_pkg.sv
// seg7_pkg: mode encoding, controller states and seven-segment glyph constants.
package seg7_pkg;
  localparam logic [1:0] MODE_HEX   = 2'b00;
  localparam logic [1:0] MODE_DEC   = 2'b01;
  localparam logic [1:0] MODE_BLANK = 2'b10;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  // active-high glyphs, segment a in bit 0
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-high seven-segment glyph.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb seg = HEX_GLYPH[nib];
endmodule

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: multi-digit hex/decimal seven-segment driver with blanking and blink.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 24,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [1:0]              mode,
  input  logic                    lz_blank,
  input  logic                    blink_en,
  output logic                    busy,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] hex_out
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int KW = $clog2(BLINK_DIV);
  state_t st, st_n;
  logic [DATA_W-1:0] bin;
  logic [BW-1:0] bcd, bcd_adj, dig;
  logic [CW-1:0] ccnt;
  logic [KW-1:0] bcnt;
  logic [63:0] padded;
  logic [7*NUM_DIGITS-1:0] seg, hex_n;
  logic accept, ovf_acc, ovf_q, lz_q, lz_p, blank_q, phase, lead;
  // busy is registered, so it also covers the cycle after DONE; gate on it too
  assign accept = wr_en && st == IDLE && !busy;
  assign padded = 64'(wr_data);
  always_comb begin
    st_n = st;
    case (st)
      IDLE: st_n = accept && mode == MODE_DEC ? CONV : IDLE;
      CONV: st_n = ccnt == CW'(DATA_W - 1) ? DONE : CONV;
      default: st_n = IDLE;
    endcase
  end
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      bcd_adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (.nib(dig[4*g+:4]), .seg(seg[7*g+:7]));
  end
  always_comb begin
    hex_n = '0;
    lead = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lead = lead && dig[4*k+:4] == 4'd0;
      hex_n[7*k+:7] = blink_en && phase ? '1 : ovf_q ? SEG_DASH :
                      (blank_q || (lz_q && lead && k != 0)) ? SEG_BLANK : ~seg[7*k+:7];
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      st <= IDLE;
      busy <= 1'b0;
      overflow <= 1'b0;
      hex_out <= {NUM_DIGITS{~HEX_GLYPH[0]}};
      dig <= '0;
      ovf_q <= 1'b0;
      lz_q <= 1'b0;
      lz_p <= 1'b0;
      blank_q <= 1'b0;
      bin <= '0;
      bcd <= '0;
      ccnt <= '0;
      ovf_acc <= 1'b0;
      bcnt <= '0;
      phase <= 1'b0;
    end else begin
      st <= st_n;
      busy <= st != IDLE;
      overflow <= ovf_q;
      hex_out <= hex_n;
      bcnt <= bcnt == KW'(BLINK_DIV - 1) ? '0 : bcnt + KW'(1);
      if (bcnt == KW'(BLINK_DIV - 1)) phase <= ~phase;
      if (accept && mode == MODE_DEC) begin
        bin <= wr_data;
        bcd <= '0;
        ccnt <= '0;
        ovf_acc <= 1'b0;
        lz_p <= lz_blank;
      end else if (accept) begin
        dig <= padded[BW-1:0];
        ovf_q <= mode != MODE_BLANK && |(padded >> BW);
        blank_q <= mode == MODE_BLANK;
        lz_q <= lz_blank;
      end
      if (st == CONV) begin
        bcd <= {bcd_adj[BW-2:0], bin[DATA_W-1]};
        bin <= bin << 1;
        ovf_acc <= ovf_acc | bcd_adj[BW-1];
        ccnt <= ccnt + CW'(1);
      end
      if (st == DONE) begin
        dig <= bcd;
        ovf_q <= ovf_acc;
        blank_q <= 1'b0;
        lz_q <= lz_p;
      end
    end
  end
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl: directed self-checking bench for seg7_display_ctrl.
module tb_seg7_display_ctrl;
  logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, lz_blank = 1'b0, blink_en = 1'b0;
  logic [23:0] wr_data = '0;
  logic [1:0] mode = 2'b00;
  logic busy, overflow;
  logic [41:0] hex_out;
  int passed = 0, failed = 0, total = 0;
  localparam logic [41:0] ZEROS   = {6{7'h40}};
  localparam logic [41:0] ABCD_LZ = {7'h7F, 7'h7F, 7'h08, 7'h03, 7'h46, 7'h21};
  localparam logic [41:0] D123456 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [41:0] ZERO_LZ = {{5{7'h7F}}, 7'h40};
  localparam logic [41:0] D42_LZ  = {{4{7'h7F}}, 7'h19, 7'h24};
  localparam logic [41:0] DASHES  = {6{7'h3F}};
  localparam logic [41:0] BLANKS  = {6{7'h7F}};
  seg7_display_ctrl #(.NUM_DIGITS(6), .DATA_W(24), .BLINK_DIV(4)) dut (
    .CLOCK_50(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .mode(mode),
    .lz_blank(lz_blank), .blink_en(blink_en), .busy(busy), .overflow(overflow), .hex_out(hex_out)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [23:0] d, input logic [1:0] m, input logic lz);
    wr_data = d;
    mode = m;
    lz_blank = lz;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("reset_hex", 64'(hex_out), 64'(ZEROS));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_ovf", 64'(overflow), 64'(0));
    wr(24'h00ABCD, 2'b00, 1'b1);
    tick();
    chk("hex_abcd_lz", 64'(hex_out), 64'(ABCD_LZ));
    chk("hex_abcd_ovf", 64'(overflow), 64'(0));
    chk("hex_abcd_busy", 64'(busy), 64'(0));
    wr(24'h123456, 2'b11, 1'b0);
    tick();
    chk("hex_mode3", 64'(hex_out), 64'(D123456));
    wr(24'h000000, 2'b00, 1'b1);
    tick();
    chk("hex_zero_lz", 64'(hex_out), 64'(ZERO_LZ));
    wr(24'h01E240, 2'b01, 1'b0);
    chk("dec_busy_T", 64'(busy), 64'(0));
    for (int i = 1; i <= 25; i++) begin
      wr_data = 24'hFFFFFF;
      mode = 2'b00;
      wr_en = (i == 4);
      tick();
      wr_en = 1'b0;
      chk($sformatf("dec_busy_T%0d", i), 64'(busy), 64'(1));
      if (i == 10) chk("dec_hold", 64'(hex_out), 64'(ZERO_LZ));
    end
    tick();
    chk("dec_123456", 64'(hex_out), 64'(D123456));
    chk("dec_busy_done", 64'(busy), 64'(0));
    chk("dec_ovf0", 64'(overflow), 64'(0));
    wr(24'h00002A, 2'b01, 1'b1);
    repeat (26) tick();
    chk("dec_42_lz", 64'(hex_out), 64'(D42_LZ));
    wr(24'h0F4240, 2'b01, 1'b0);
    repeat (26) tick();
    chk("dec_ovf", 64'(overflow), 64'(1));
    chk("dec_ovf_dash", 64'(hex_out), 64'(DASHES));
    wr(24'h123456, 2'b10, 1'b0);
    tick();
    chk("blank_hex", 64'(hex_out), 64'(BLANKS));
    chk("blank_ovf", 64'(overflow), 64'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      blink_en = (n != 7);
      tick();
      chk($sformatf("blink_%0d", n), 64'(hex_out),
          (n != 7 && ((n - 1) / 4) % 2 == 1) ? 64'h3FF_FFFF_FFFF : 64'(ZEROS));
    end
    blink_en = 1'b0;
    tick();
    wr(24'h01E240, 2'b01, 1'b0);
    repeat (9) tick();
    chk("abort_busy_pre", 64'(busy), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hex", 64'(hex_out), 64'(ZEROS));
    repeat (20) tick();
    chk("abort_hold", 64'(hex_out), 64'(ZEROS));
    chk("abort_ovf", 64'(overflow), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
